// File: rtl/regfile_dump_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_if
// Signal bundle between the register-file dump reader and its surroundings
// (start source, register file read port, word consumer).
//
// Handshake: a word moves when out_valid && out_ready are both high at a
// posedge. The producer raises out_valid independently of out_ready, and once
// raised keeps out_valid/out_data/out_index/out_last stable until that
// handshake.
//
// Signals (direction seen from the master = the dump reader):
//   start      in   begin a dump (looked at only while idle)
//   rf_addr    out  register file read address
//   rf_data    in   combinational read data for rf_addr
//   out_valid  out  out_data/out_index/out_last are valid
//   out_ready  in   consumer accepts the word this cycle
//   out_data   out  register value
//   out_index  out  register number of out_data
//   out_last   out  final word of the dump
//   busy       out  dump in progress
//   done       out  one-cycle pulse after the final word is accepted
//   dbg_state  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
interface regfile_dump_if #(
   parameter int REGF_WIDTH = 32
);
   logic                  start;
   logic [4:0]            rf_addr;
   logic [REGF_WIDTH-1:0] rf_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [REGF_WIDTH-1:0] out_data;
   logic [4:0]            out_index;
   logic                  out_last;
   logic                  busy;
   logic                  done;
   logic [1:0]            dbg_state;

   modport master (
      input  start, rf_data, out_ready,
      output rf_addr, out_valid, out_data, out_index, out_last, busy, done,
             dbg_state
   );

   modport slave (
      output start, rf_data, out_ready,
      input  rf_addr, out_valid, out_data, out_index, out_last, busy, done,
             dbg_state
   );
endinterface

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
// Walks the RV32I register file through a dedicated combinational read port
// and streams every register out as one word on a valid/ready interface, so a
// watchdog timeout or debug request can be diagnosed from hardware alone.
//
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    regfile_dump_if.master (start, read port, output stream,
//          busy/done status, dbg_state)
//
// Parameters:
//   REGF_WIDTH  width of a register word (must match the interface)
//   NUM_REGS    number of registers walked, 2..32
//
// Build option:
//   REGF_DUMP_SKIP_X0_EN  when defined the walk starts at x1, so x0 is never
//                         emitted; otherwise x0 is emitted as value 0.
//
// Each word costs two cycles: READ captures the register, SEND offers it
// until accepted. The dump is not an atomic snapshot; each word holds the
// register value seen at its own READ cycle.
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
   parameter int REGF_WIDTH = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   regfile_dump_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

`ifdef REGF_DUMP_SKIP_X0_EN
   localparam logic [4:0] FIRST_IDX = 5'd1;
`else
   localparam logic [4:0] FIRST_IDX = 5'd0;
`endif
   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

   state_t                state_q,     state_d;
   logic [4:0]            idx_q,       idx_d;
   logic [REGF_WIDTH-1:0] out_data_q,  out_data_d;
   logic [4:0]            out_index_q, out_index_d;
   logic                  out_last_q,  out_last_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q,      busy_d;
   logic                  done_q,      done_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;

      case (state_q)
         S_IDLE: begin
            idx_d = 5'd0;
            if (bus.start) begin
               idx_d   = FIRST_IDX;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // x0 is hardwired zero regardless of what the read port returns.
            out_data_d  = (idx_q == 5'd0) ? '0 : bus.rf_data;
            out_index_d = idx_q;
            out_last_d  = (idx_q == LAST_IDX);
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (out_valid_q && bus.out_ready) begin
               if (out_last_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = S_READ;
               end
            end
         end
         S_DONE: begin
            idx_d   = 5'd0;
            state_d = S_IDLE;
         end
         default: begin
            idx_d   = 5'd0;
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered copies of the next state, so they never
      // depend combinationally on out_ready.
      out_valid_d = (state_d == S_SEND);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= 5'd0;
         out_data_q  <= '0;
         out_index_q <= 5'd0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.rf_addr   = idx_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_index = out_index_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
// Self-checking bench for regfile_dump_reader. A register file array drives
// the combinational read port; a negedge monitor records every accepted word
// with its cycle number; each test task builds the expected word list from
// the dump rules and compares it inline.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

   localparam int W        = 32;
   localparam int NUM_REGS = 32;
`ifdef REGF_DUMP_SKIP_X0_EN
   localparam int FIRST_IDX = 1;
`else
   localparam int FIRST_IDX = 0;
`endif
   localparam int NWORDS = NUM_REGS - FIRST_IDX;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regfile_dump_if #(.REGF_WIDTH(W)) bus ();

   regfile_dump_reader #(.REGF_WIDTH(W), .NUM_REGS(NUM_REGS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Register file model: combinational read port.
   logic [W-1:0] rf_mem [NUM_REGS];
   assign bus.rf_data = rf_mem[bus.rf_addr];

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [W+5:0] exp_q[$];     // {last, index, data}
   logic [W+5:0] obs_q[$];
   int           obs_cyc[$];
   int           done_cyc_q[$];
   int           cyc = 0;
   int           done_cnt = 0;
   int           stab_err = 0;
   int           stall7 = 0;
   logic         hold_pend = 1'b0;
   logic [W+5:0] hold_word;

   // out_ready driver: 0 = always ready, 1 = random with a long stall on
   // index 7, 2 = never ready.
   int ready_mode = 0;
   int stall_left = 0;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: bus.out_ready = 1'b1;
         1: begin
            if (bus.out_valid && bus.out_index == 5'd7 && stall_left > 0) begin
               bus.out_ready = 1'b0;
               stall_left--;
            end else begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor: samples at negedge, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (rst_n !== 1'b1) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            if (!(bus.out_valid &&
                  {bus.out_last, bus.out_index, bus.out_data} == hold_word))
               stab_err++;
         end
         if (bus.out_valid && bus.out_ready) begin
            obs_q.push_back({bus.out_last, bus.out_index, bus.out_data});
            obs_cyc.push_back(cyc);
            hold_pend = 1'b0;
         end else if (bus.out_valid) begin
            hold_pend = 1'b1;
            hold_word = {bus.out_last, bus.out_index, bus.out_data};
            if (bus.out_index == 5'd7) stall7++;
         end else begin
            hold_pend = 1'b0;
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
         end
      end
   end

   // ---------------- model / driver tasks ----------------
   task automatic preload_seq();
      rf_mem[0] = 32'hBAD0_0000 | W'($urandom_range(1, 16'hFFFF));
      for (int i = 1; i < NUM_REGS; i++) rf_mem[i] = 32'h1000 + W'(i);
   endtask

   task automatic preload_rand();
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
   endtask

   // Expected dump: one word per walked index; x0 reads as 0; last flag on
   // the final register only.
   task automatic build_expected();
      exp_q.delete();
      for (int i = FIRST_IDX; i < NUM_REGS; i++)
         exp_q.push_back({(i == NUM_REGS - 1), 5'(i),
                          (i == 0) ? {W{1'b0}} : rf_mem[i]});
   endtask

   task automatic clear_obs();
      obs_q.delete();
      obs_cyc.delete();
   endtask

   // Returns the monitor cycle count just after the edge that samples start.
   task automatic pulse_start(output int k);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      k = cyc;
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      int c0;
      c0 = done_cnt;
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt != c0) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_valid_index(input logic [4:0] target, input int budget,
                                   output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_index == target) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data,
           bus.out_index, bus.rf_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b data=%h idx=%0d addr=%0d, required all 0",
                  bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data,
                  bus.out_index, bus.rf_addr);
      end
      n_checks++;
      if (bus.dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d, required 0 (IDLE)", bus.dbg_state);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b valid=%b, required 0 0",
                  bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_basic_dump();
      int k;
      bit to;
      ready_mode = 0;
      preload_seq();
      build_expected();
      clear_obs();
      pulse_start(k);
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.rf_addr !== 5'(FIRST_IDX)) begin
         n_fail++;
         $display("FAIL basic_read_cycle: got busy=%b valid=%b addr=%0d, required 1 0 %0d",
                  bus.busy, bus.out_valid, bus.rf_addr, FIRST_IDX);
      end
      wait_done(300, to);
      n_checks++;
      if (to) begin
         n_fail++;
         $display("FAIL basic_done_timeout: no done within 300 cycles");
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL basic_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL basic_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
         end
      end
      if (obs_cyc.size() == NWORDS && done_cyc_q.size() > 0) begin
         n_checks++;
         if (obs_cyc[0] - k != 2) begin
            n_fail++;
            $display("FAIL basic_first_latency: got %0d cycles, required 2", obs_cyc[0] - k);
         end
         n_checks++;
         if (obs_cyc[NWORDS-1] - k != 2 * NWORDS) begin
            n_fail++;
            $display("FAIL basic_last_latency: got %0d cycles, required %0d",
                     obs_cyc[NWORDS-1] - k, 2 * NWORDS);
         end
         n_checks++;
         if (done_cyc_q[done_cyc_q.size()-1] - obs_cyc[NWORDS-1] != 1) begin
            n_fail++;
            $display("FAIL basic_done_timing: got %0d cycles after last handshake, required 1",
                     done_cyc_q[done_cyc_q.size()-1] - obs_cyc[NWORDS-1]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_idle_after_done: got busy=%b done=%b, required 0 0",
                  bus.busy, bus.done);
      end
   endtask

   task automatic test_backpressure();
      int k;
      bit to;
      preload_seq();
      build_expected();
      clear_obs();
      stab_err   = 0;
      stall7     = 0;
      stall_left = 10;
      ready_mode = 1;
      pulse_start(k);
      wait_done(1000, to);
      ready_mode = 0;
      n_checks++;
      if (to) begin
         n_fail++;
         $display("FAIL bp_done_timeout: no done within 1000 cycles");
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL bp_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL bp_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (stab_err != 0) begin
         n_fail++;
         $display("FAIL bp_stable: got %0d hold violations, required 0", stab_err);
      end
      n_checks++;
      if (stall7 < 10) begin
         n_fail++;
         $display("FAIL bp_stall7: got %0d stalled cycles on index 7, required >= 10", stall7);
      end
   endtask

   task automatic test_start_while_busy();
      int k, c0;
      bit to, found;
      ready_mode = 0;
      preload_rand();
      build_expected();
      clear_obs();
      c0 = done_cnt;
      pulse_start(k);
      wait_valid_index(5'd5, 100, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL swb_reach5: index 5 not offered within 100 cycles");
      end
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done(300, to);
      repeat (80) @(posedge clk);
      n_checks++;
      if (to || done_cnt - c0 != 1) begin
         n_fail++;
         $display("FAIL swb_done_count: got %0d done pulses, required 1", done_cnt - c0);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL swb_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL swb_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL swb_busy_fall: got busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_dump();
      int k, c0;
      bit to, found;
      ready_mode = 0;
      preload_rand();
      clear_obs();
      c0 = done_cnt;
      pulse_start(k);
      wait_valid_index(5'd12, 100, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL rmd_reach12: index 12 not offered within 100 cycles");
      end
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data,
           bus.out_index, bus.rf_addr} !== '0) begin
         n_fail++;
         $display("FAIL rmd_outputs: got v=%b l=%b b=%b d=%b data=%h idx=%0d addr=%0d, required all 0",
                  bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data,
                  bus.out_index, bus.rf_addr);
      end
      repeat (5) @(posedge clk);
      n_checks++;
      if (done_cnt != c0) begin
         n_fail++;
         $display("FAIL rmd_no_done: got %0d done pulses, required 0", done_cnt - c0);
      end
      build_expected();
      clear_obs();
      pulse_start(k);
      wait_done(300, to);
      n_checks++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rmd_restart_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rmd_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_concurrent_write();
      int k, e;
      bit to, found;
      ready_mode = 0;
      preload_seq();
      build_expected();
      // A write landing in the READ cycle of x20 must be the value captured.
      e = 20 - FIRST_IDX;
      exp_q[e] = {1'b0, 5'd20, 32'h0000_DEAD};
      clear_obs();
      pulse_start(k);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus.busy && !bus.out_valid && !bus.done && bus.rf_addr == 5'd20) begin
            rf_mem[20] = 32'h0000_DEAD;
            found = 1'b1;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL cw_read20: READ of x20 not reached within 100 cycles");
      end
      wait_done(300, to);
      n_checks++;
      if (to || obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL cw_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL cw_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   // start held high: ignored while busy and during DONE, accepted in the
   // first idle cycle after DONE.
   task automatic test_back_to_back();
      int d0;
      bit to1, to2;
      ready_mode = 0;
      preload_rand();
      build_expected();
      clear_obs();
      d0 = done_cyc_q.size();
      @(posedge clk); #1 bus.start = 1'b1;
      wait_done(300, to1);
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done(300, to2);
      n_checks++;
      if (to1 || to2 || obs_q.size() != 2 * NWORDS) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d words, required %0d", obs_q.size(), 2 * NWORDS);
      end
      for (int i = 0; i < 2 * NWORDS && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i % NWORDS]) begin
            n_fail++;
            $display("FAIL b2b_word[%0d]: got %h, required %h", i, obs_q[i], exp_q[i % NWORDS]);
         end
      end
      if (obs_cyc.size() > NWORDS && done_cyc_q.size() > d0) begin
         n_checks++;
         if (obs_cyc[NWORDS] - done_cyc_q[d0] != 3) begin
            n_fail++;
            $display("FAIL b2b_restart_gap: got %0d cycles from done to next word, required 3",
                     obs_cyc[NWORDS] - done_cyc_q[d0]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
      test_reset();
      test_basic_dump();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_dump();
      test_concurrent_write();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
